// File: rtl/dmem_pkg.sv
// Shared widths, requester IDs and response-owner encoding for the data-memory arbiter.
package dmem_pkg;
  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 32;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_CPU  = 2'd1,
    RESP_HOST = 2'd2
  } resp_e;
endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating host starvation counter; clear has priority over increment.
module dmem_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       at_max
);
  assign at_max = (cnt == 4'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !at_max)  cnt <= cnt + 4'd1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data BRAM arbiter: CPU has fixed priority, bounded by a host
// starvation counter; host_lock gives the host exclusive ownership.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  logic       cpu_win, host_win, host_force;
  logic [3:0] starve_cnt;
  logic       starve_at_max;
  resp_e      resp_q, resp_d;
  logic [DATA_W-1:0] cpu_hold, host_hold;

  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (rst & host_req & ~host_win & ~starve_at_max),
    .clr    (host_win | ~host_req),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  assign host_force = (starve_cnt == 4'(STARVE_MAX)) & host_req;

  // Reset blocks every grant, so cpu_stall follows cpu_req while rst is low.
  assign host_win  = rst & host_req & (host_lock | host_force | ~cpu_req);
  assign cpu_win   = rst & cpu_req & ~host_lock & ~host_force;
  assign cpu_stall = cpu_req & ~cpu_win;
  assign host_gnt  = host_win;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    resp_d   = RESP_NONE;
    if (cpu_win) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
      if (!cpu_we) resp_d = RESP_CPU;
    end else if (host_win) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_din  = host_wdata;
      if (!host_we) resp_d = RESP_HOST;
    end
  end

  // Async reset drops any response still pending for the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) resp_q <= RESP_NONE;
    else      resp_q <= resp_d;
  end

  assign cpu_rvalid  = (resp_q == RESP_CPU);
  assign host_rvalid = (resp_q == RESP_HOST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_hold  <= '0;
      host_hold <= '0;
    end else begin
      if (cpu_rvalid)  cpu_hold  <= mem_dout;
      if (host_rvalid) host_hold <= mem_dout;
    end
  end

  assign cpu_rdata  = cpu_rvalid  ? mem_dout : cpu_hold;
  assign host_rdata = host_rvalid ? mem_dout : host_hold;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the data BRAM between the CPU datapath (requester 0) and a host loader/debug port (requester 1). It sits between the datapath's load/store signals and the data BRAM. It stalls the CPU while the host owns the port and returns read data with a valid pulse to whichever requester issued the read. Fixed CPU priority is bounded by a host starvation counter. A host lock lets the loader halt the CPU.

## Interface
Parameters:
- ADDR_W, 16, word-address width of the data BRAM
- DATA_W, 32, data word width
- STARVE_MAX, 4, denied host-request cycles before the host is forced through; legal range 1..15

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU memory access request (MR | MW)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_stall  out  1  CPU must hold its request and freeze the PC
- cpu_rdata  out  DATA_W  CPU load data
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- host_req  in  1  host access request
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_lock  in  1  host owns the port exclusively; CPU is never granted
- host_gnt  out  1  host access issued this cycle
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid this cycle
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_din  out  DATA_W  BRAM write data
- mem_dout  in  DATA_W  BRAM read data; one-cycle latency; BRAM clocked by clk

## Operation
- Each cycle, at most one access is issued. The winner's addr, we and wdata drive the mem_* ports combinationally. With no winner, mem_we=0 and mem_addr/mem_din hold 0.
- Winner selection, evaluated in order:
  - rst low: no winner.
  - host_lock=1: host wins if host_req=1; otherwise no winner.
  - starve_cnt==STARVE_MAX and host_req=1: host wins.
  - cpu_req=1: CPU wins.
  - host_req=1: host wins.
- cpu_stall = cpu_req & ~cpu_win. host_gnt = host_win.
- Requesters hold req, we, addr and wdata stable until granted. Changes while stalled or ungranted are legal; the winner is sampled in the issue cycle.
- Starvation counter, 4 bits, saturating at STARVE_MAX:
  - increments when host_req=1 and host loses;
  - clears when host wins or host_req=0.
- Read response:
  - A read issued in cycle N sets the owner's rvalid for cycle N+1 only. A write sets no rvalid.
  - The owner's rdata equals mem_dout while its rvalid=1. rdata is captured into a holding register at the end of that cycle and held until that owner's next read response.
  - The non-owner's rdata is unchanged.
- Owner tracking uses a registered response state: RESP_NONE, RESP_CPU, RESP_HOST. It is loaded every cycle from the issue decision, including a read immediately following a read.

## Timing
- Grant and stall are combinational in the issue cycle. Read latency is 1 cycle. Back-to-back issue is allowed every cycle with no bubbles.
- Reset values: cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0, starve_cnt=0, response state RESP_NONE. While rst is low: host_gnt=0, mem_we=0, and cpu_stall=cpu_req.
- Reset asserted between issue and response: the pending response is dropped, with no rvalid after deassertion.
- host_lock rising while a CPU read is in flight: that response still completes in N+1.
- Simultaneous requests: the CPU wins unless starve_cnt==STARVE_MAX or host_lock=1. The loser is stalled, with no dropped request.
- STARVE_MAX=1: after any single denied cycle, the host wins the next contested cycle.

## Structure
- A shared package holds DMEM_ADDR_W, DMEM_DATA_W, the requester IDs REQ_CPU=0 and REQ_HOST=1, and the response-state encoding RESP_NONE/RESP_CPU/RESP_HOST.
- One sub-module, dmem_starve_ctr, contains the saturating starvation counter. Its inputs are inc and clr; its output is the count plus an at_max flag.
- All other logic (winner mux, response register, rdata holding registers) lives in dmem_arbiter.

## Test plan
- Reset: assert rst low mid-read with cpu_req=1 -> all outputs at their reset values, mem_we=0, no rvalid after release.
- CPU only: read addr 0x0010, with the BRAM holding 0xDEADBEEF -> cpu_stall=0; in N+1, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF; cpu_rdata still 0xDEADBEEF at N+5.
- Contention, STARVE_MAX=4: cpu_req and host_req held high -> the CPU wins cycles 0-3 and the host wins cycle 4 with host_gnt=1 and cpu_stall=1 for that cycle only; the counter returns to 0.
- host_lock=1 with a host write of 0x12345678 to 0x0020 while cpu_req=1 -> cpu_stall=1 throughout and mem_we=1 in the grant cycle. Release the lock, then the CPU reads 0x0020 and receives 0x12345678.
- Back-to-back mixed traffic: CPU read, host read, CPU write on consecutive cycles -> cpu_rvalid at N+1, host_rvalid at N+2, no rvalid at N+3; each rdata goes only to its owner.
